// File: rtl/ceespu_fetch.sv
// rtl/ceespu_fetch.sv - instruction fetch stage: PC generation, imem requests, response FIFO, redirect/drop handling (optional counters: CEESPU_FETCH_PERF_EN)
module ceespu_fetch #(
    parameter logic [24:0] RESET_PC   = 25'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_stall,
    input  logic        I_branch,
    input  logic [24:0] I_branchTarget,
    output logic        O_imem_req,
    output logic [24:0] O_imem_addr,
    input  logic        I_imem_ready,
    input  logic        I_imem_valid,
    input  logic [31:0] I_imem_data,
    output logic [31:0] O_instruction,
    output logic [24:0] O_PC,
    output logic        O_justBranched,
    output logic        O_bubble
`ifdef CEESPU_FETCH_PERF_EN
    ,
    output logic [31:0] O_perf_fetched,
    output logic [31:0] O_perf_dropped,
    output logic [31:0] O_perf_bubbles
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [24:0]   fetch_pc;
    logic [CW-1:0] inflight, inflight_nx;
    logic [CW-1:0] drop, drop_nx;
    logic          jb_pend;

    // instruction buffer
    logic [31:0]   f_data [FIFO_DEPTH];
    logic [24:0]   f_pc   [FIFO_DEPTH];
    logic          f_jb   [FIFO_DEPTH];
    logic [AW-1:0] f_rd, f_wr;
    logic [CW-1:0] f_cnt;

    // per-request tags, consumed in order as responses return
    logic [24:0]   tag_pc [FIFO_DEPTH];
    logic          tag_jb [FIFO_DEPTH];
    logic [AW-1:0] t_rd, t_wr;

    logic accept, resp, drop_resp, push, pop;

    // a response with nothing outstanding (e.g. stale across reset) is ignored
    assign accept    = O_imem_req && I_imem_ready;
    assign resp      = I_imem_valid && (inflight != '0);
    assign drop_resp = resp && (drop != '0);
    assign push      = resp && (drop == '0) && !I_branch;
    assign pop       = !I_stall && (f_cnt != '0) && !I_branch;

    assign inflight_nx = inflight + CW'(accept) - CW'(resp);

    // issue only in RUN and only while buffer credit remains for every outstanding request
    assign O_imem_req  = (state == RUN) && (({1'b0, inflight} + {1'b0, f_cnt}) < DEPTH_C);
    assign O_imem_addr = fetch_pc;

    assign O_bubble       = (f_cnt == '0);
    assign O_instruction  = O_bubble ? 32'h0 : f_data[f_rd];
    assign O_PC           = O_bubble ? 25'h0 : f_pc[f_rd];
    assign O_justBranched = O_bubble ? 1'b0  : f_jb[f_rd];

    // next state and drop count; a redirect drops everything still outstanding after this cycle
    always_comb begin
        state_nx = state;
        drop_nx  = drop;
        unique case (state)
            BOOT: begin
                state_nx = RUN;
                if (I_branch) begin
                    drop_nx = inflight_nx;
                end
            end
            RUN: begin
                if (I_branch) begin
                    drop_nx  = inflight_nx;
                    state_nx = (inflight_nx != '0) ? DRAIN : RUN;
                end else if (drop_resp) begin
                    drop_nx = drop - CW'(1);
                end
            end
            DRAIN: begin
                if (I_branch) begin
                    drop_nx = inflight_nx;
                end else if (drop_resp) begin
                    drop_nx = drop - CW'(1);
                end
                state_nx = (drop_nx == '0) ? RUN : DRAIN;
            end
            default: begin
                state_nx = BOOT;
                drop_nx  = '0;
            end
        endcase
    end

    // state, PC, outstanding count and sticky just-branched flag
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            jb_pend  <= 1'b0;
        end else begin
            state    <= state_nx;
            inflight <= inflight_nx;
            drop     <= drop_nx;
            if (I_branch) begin
                fetch_pc <= I_branchTarget;
                jb_pend  <= 1'b1;
            end else if (accept) begin
                fetch_pc <= fetch_pc + 25'd1;
                jb_pend  <= 1'b0;
            end
        end
    end

    // tag queue pointers
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            t_rd <= '0;
            t_wr <= '0;
        end else begin
            if (accept) t_wr <= t_wr + AW'(1);
            if (resp)   t_rd <= t_rd + AW'(1);
        end
    end

    // tag storage; the request accepted in a redirect cycle keeps the pre-redirect flag
    always_ff @(posedge I_clk) begin
        if (accept) begin
            tag_pc[t_wr] <= fetch_pc;
            tag_jb[t_wr] <= jb_pend;
        end
    end

    // buffer pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            f_rd  <= '0;
            f_wr  <= '0;
            f_cnt <= '0;
        end else if (I_branch) begin
            f_rd  <= '0;
            f_wr  <= '0;
            f_cnt <= '0;
        end else begin
            if (push) f_wr <= f_wr + AW'(1);
            if (pop)  f_rd <= f_rd + AW'(1);
            f_cnt <= f_cnt + CW'(push) - CW'(pop);
        end
    end

    // buffer storage
    always_ff @(posedge I_clk) begin
        if (push) begin
            f_data[f_wr] <= I_imem_data;
            f_pc[f_wr]   <= tag_pc[t_rd];
            f_jb[f_wr]   <= tag_jb[t_rd];
        end
    end

`ifdef CEESPU_FETCH_PERF_EN
    // event counters, free-running with wrap
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            O_perf_fetched <= 32'h0;
            O_perf_dropped <= 32'h0;
            O_perf_bubbles <= 32'h0;
        end else begin
            if (push)      O_perf_fetched <= O_perf_fetched + 32'd1;
            if (drop_resp) O_perf_dropped <= O_perf_dropped + 32'd1;
            if (O_bubble && !I_stall && (state != BOOT))
                O_perf_bubbles <= O_perf_bubbles + 32'd1;
        end
    end
`endif

endmodule
